// File: rtl/cpu_params.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_params
//  Description : Core-wide sizing parameters shared by the integer backend.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_params;

   // Number of integer reservation-station entries seen by the scheduler.
   localparam int RS_DEPTH = 8;

endpackage : cpu_params
`default_nettype wire

// File: rtl/int_rs_types.sv
`default_nettype none
// ============================================================================
//  Package     : int_rs_types
//  Description : Types shared by the integer reservation-station scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_rs_types;

   // One age-matrix row at the core's default depth: bit j set means the
   // row's entry is older than entry j.
   typedef logic [cpu_params::RS_DEPTH-1:0] age_row_t;

endpackage : int_rs_types
`default_nettype wire

// File: rtl/int_rs_age_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : int_rs_age_matrix
//  Description : Age matrix for the integer RS. Records relative allocation
//                order of entries and flags every requester that has no
//                older requester. The newly pushed entry becomes youngest.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_rs_age_matrix
   import int_rs_types::*;
#(
   parameter int RS_DEPTH = cpu_params::RS_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [RS_DEPTH-1:0] push,
   input  logic [RS_DEPTH-1:0] req,
   output logic [RS_DEPTH-1:0] oldest
);

   // r_older[i][j] = 1 : entry i was allocated before entry j
   logic [RS_DEPTH-1:0] r_older [RS_DEPTH];
   logic [RS_DEPTH-1:0] w_blocked;

   // Pushed entry clears its own row (older than nobody) and sets its column
   // in every other row (everybody else is older); the diagonal never sets.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_older[i] <= '0;
         end
      end else begin
         for (int k = 0; k < RS_DEPTH; k++) begin
            if (push[k]) begin
               r_older[k] <= '0;
               for (int j = 0; j < RS_DEPTH; j++) begin
                  if (j != k) begin
                     r_older[j][k] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   // A requester is a candidate when no other requester is older than it.
   always_comb begin
      w_blocked = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (req[j] && r_older[j][i]) begin
               w_blocked[i] = 1'b1;
            end
         end
      end
      oldest = req & ~w_blocked;
   end

endmodule : int_rs_age_matrix
`default_nettype wire

// File: rtl/int_rs_age_sched.sv
`default_nettype none
// ============================================================================
//  Module      : int_rs_age_sched
//  Description : Integer reservation-station scheduler. Allocates the lowest
//                free entry to the dispatched uop, grants one requesting entry
//                per cycle to the integer FU, and tracks occupancy.
//                Build option INT_RS_AGE_ORDER_EN: when defined, the grant
//                goes to the oldest requester (age matrix); when undefined,
//                to the lowest-index requester and no age matrix is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_rs_age_sched #(
   parameter int RS_DEPTH = cpu_params::RS_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [RS_DEPTH-1:0]           entry_valid,
   input  logic [RS_DEPTH-1:0]           entry_request,
   output logic [RS_DEPTH-1:0]           entry_grant,
   output logic [RS_DEPTH-1:0]           entry_push,
   input  logic                          dispatch_valid,
   output logic                          dispatch_ready,
   input  logic                          fu_ready,
   output logic                          issue_valid,
   output logic [$clog2(RS_DEPTH)-1:0]   issue_idx,
   output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
);

   localparam int c_IDX_W = $clog2(RS_DEPTH);
   localparam int c_OCC_W = $clog2(RS_DEPTH+1);

   logic [RS_DEPTH-1:0] w_free;
   logic [RS_DEPTH-1:0] w_push_sel;
   logic [RS_DEPTH-1:0] w_elig;
   logic [RS_DEPTH-1:0] w_cand;
   logic [RS_DEPTH-1:0] w_grant_sel;
   logic                w_ready;
   logic                w_grant_en;
   logic                w_push_any;
   logic                w_grant_any;
   logic [c_OCC_W-1:0]  r_occ;

   // Allocation: lowest free entry; a granted entry is still valid this cycle
   // so it cannot be reallocated until the RS drops its valid bit.
   always_comb begin
      w_free         = ~entry_valid;
      w_push_sel     = w_free & (~w_free + 1'b1);
      w_ready        = !rst && !flush && (|w_free);
      dispatch_ready = w_ready;
      entry_push     = (dispatch_valid && w_ready) ? w_push_sel : '0;
   end

   // Only valid entries may request; an entry pushed this cycle is not yet
   // valid, so it cannot be granted before the following cycle.
   assign w_elig = entry_request & entry_valid;

`ifdef INT_RS_AGE_ORDER_EN
   int_rs_age_matrix #(
      .RS_DEPTH (RS_DEPTH)
   ) u_age_matrix (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .push   (entry_push),
      .req    (w_elig),
      .oldest (w_cand)
   );
`else
   assign w_cand = w_elig;
`endif

   // Grant: lowest-index candidate keeps the result one-hot even when the
   // age matrix holds no relation between requesters (e.g. after reset).
   always_comb begin
      w_grant_sel = w_cand & (~w_cand + 1'b1);
      w_grant_en  = !rst && !flush && fu_ready;
      entry_grant = w_grant_en ? w_grant_sel : '0;
      issue_valid = |entry_grant;
   end

   // Binary encode of the one-hot grant; zero when nothing is granted.
   always_comb begin
      issue_idx = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (entry_grant[i]) begin
            issue_idx = issue_idx | c_IDX_W'(i);
         end
      end
   end

   assign w_push_any  = |entry_push;
   assign w_grant_any = |entry_grant;

   // Occupancy: +1 on push alone, -1 on grant alone, saturating at both ends.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_occ <= '0;
      end else if (w_push_any && !w_grant_any) begin
         if (r_occ != c_OCC_W'(RS_DEPTH)) begin
            r_occ <= r_occ + 1'b1;
         end
      end else if (w_grant_any && !w_push_any) begin
         if (r_occ != '0) begin
            r_occ <= r_occ - 1'b1;
         end
      end
   end

   assign occupancy = r_occ;

endmodule : int_rs_age_sched
`default_nettype wire

// File: tb/tb_int_rs_age_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_rs_age_sched
//  Description : Self-checking bench for int_rs_age_sched at RS_DEPTH=4.
//                The bench plays the RS: it owns entry_valid, driven from its
//                own reference model (push-order queue + valid vector).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_rs_age_sched;

   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [D-1:0] entry_valid;
   logic [D-1:0] entry_request;
   logic [D-1:0] entry_grant;
   logic [D-1:0] entry_push;
   logic         dispatch_valid;
   logic         dispatch_ready;
   logic         fu_ready;
   logic         issue_valid;
   logic [1:0]   issue_idx;
   logic [2:0]   occupancy;

   int_rs_age_sched #(.RS_DEPTH(D)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .entry_valid    (entry_valid),
      .entry_request  (entry_request),
      .entry_grant    (entry_grant),
      .entry_push     (entry_push),
      .dispatch_valid (dispatch_valid),
      .dispatch_ready (dispatch_ready),
      .fu_ready       (fu_ready),
      .issue_valid    (issue_valid),
      .issue_idx      (issue_idx),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [D-1:0] m_valid;
   int           m_q[$];     // entry indices in allocation order, oldest first
   int           m_occ;

   // DUT outputs sampled in the last step
   logic [D-1:0] s_push, s_grant;
   logic         s_ready, s_iv;
   logic [1:0]   s_idx;
   logic [2:0]   s_occ;

   typedef struct {
      logic [D-1:0] v;
      logic         dv;
      logic [D-1:0] req;
      logic         fu;
      logic         fl;
      logic         exp_ready;
      logic [D-1:0] exp_push;
      logic [D-1:0] exp_grant;
      logic [1:0]   exp_idx;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, predict from the model, compare at negedge,
   // then advance the model at posedge.
   task automatic step(input logic [D-1:0] v, input logic dv, input logic [D-1:0] req,
                       input logic fu, input logic fl, input logic rs, input bit chk_occ);
      logic         e_ready;
      logic [D-1:0] e_push, e_grant, elig;
      logic [1:0]   e_idx;
      entry_valid    = v;
      dispatch_valid = dv;
      entry_request  = req;
      fu_ready       = fu;
      flush          = fl;
      rst            = rs;

      e_ready = !rs && !fl && (v != {D{1'b1}});
      e_push  = '0;
      if (e_ready && dv)
         for (int i = 0; i < D; i++)
            if (!v[i] && e_push == '0) e_push[i] = 1'b1;
      elig    = req & v;
      e_grant = '0;
      if (!rs && !fl && fu) begin
`ifdef INT_RS_AGE_ORDER_EN
         foreach (m_q[k])
            if (e_grant == '0 && elig[m_q[k]]) e_grant[m_q[k]] = 1'b1;
`endif
         // entries with no recorded age (table rows) fall back to lowest index
         for (int i = 0; i < D; i++)
            if (elig[i] && e_grant == '0) e_grant[i] = 1'b1;
      end
      e_idx = '0;
      for (int i = 0; i < D; i++)
         if (e_grant[i]) e_idx = 2'(i);

      @(negedge clk);
      s_push = entry_push; s_grant = entry_grant; s_ready = dispatch_ready;
      s_iv = issue_valid; s_idx = issue_idx; s_occ = occupancy;
      check("dispatch_ready", 32'(s_ready), 32'(e_ready));
      check("entry_push", 32'(s_push), 32'(e_push));
      check("entry_grant", 32'(s_grant), 32'(e_grant));
      check("issue_valid", 32'(s_iv), 32'(|e_grant));
      check("issue_idx", 32'(s_idx), 32'(e_idx));
      if (chk_occ) check("occupancy", 32'(s_occ), 32'(m_occ));

      @(posedge clk);
      if (rs || fl) begin
         m_valid = '0;
         m_q.delete();
         m_occ = 0;
      end else begin
         for (int k = m_q.size() - 1; k >= 0; k--)
            if (e_grant[m_q[k]]) m_q.delete(k);
         for (int i = 0; i < D; i++)
            if (e_push[i]) m_q.push_back(i);
         m_valid = (v | e_push) & ~e_grant;
         if (e_push != '0 && e_grant == '0 && m_occ < D) m_occ++;
         else if (e_grant != '0 && e_push == '0 && m_occ > 0) m_occ--;
      end
      #1;
   endtask

   task automatic cyc(input logic dv, input logic [D-1:0] req, input logic fu,
                      input logic fl, input logic rs);
      step(m_valid, dv, req, fu, fl, rs, 1'b1);
   endtask

   initial begin
      m_valid = '0; m_occ = 0;
      rst = 1'b1; flush = 1'b0; entry_valid = '0; entry_request = '0;
      dispatch_valid = 1'b0; fu_ready = 1'b0;

      //                v     dv  req   fu  fl  rdy push   grant  idx
      tbl[0] = '{4'b0000, 1, 4'b0000, 1, 0, 1, 4'b0001, 4'b0000, 2'd0};
      tbl[1] = '{4'b0001, 1, 4'b0001, 1, 0, 1, 4'b0010, 4'b0001, 2'd0};
      tbl[2] = '{4'b1011, 1, 4'b1000, 1, 0, 1, 4'b0100, 4'b1000, 2'd3};
      tbl[3] = '{4'b1111, 1, 4'b0100, 1, 0, 0, 4'b0000, 4'b0100, 2'd2};
      tbl[4] = '{4'b0111, 0, 4'b0010, 0, 0, 1, 4'b0000, 4'b0000, 2'd0};
      tbl[5] = '{4'b0101, 1, 4'b1010, 1, 0, 1, 4'b0010, 4'b0000, 2'd0};
      tbl[6] = '{4'b1110, 1, 4'b0010, 1, 1, 0, 4'b0000, 4'b0000, 2'd0};
      tbl[7] = '{4'b1101, 0, 4'b0001, 1, 0, 1, 4'b0000, 4'b0001, 2'd0};
      tbl[8] = '{4'b0010, 1, 4'b0010, 1, 0, 1, 4'b0001, 4'b0010, 2'd1};
      tbl[9] = '{4'b1110, 1, 4'b1000, 1, 0, 1, 4'b0001, 4'b1000, 2'd3};

      @(posedge clk); #1;
      // reset state: every output zero
      cyc(1, 4'hF, 1, 0, 1);
      check("rst_occupancy", 32'(occupancy), 32'd0);

      // table vectors
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].dv, tbl[i].req, tbl[i].fu, tbl[i].fl, 1'b0, 1'b0);
         check("tbl_ready", 32'(s_ready), 32'(tbl[i].exp_ready));
         check("tbl_push", 32'(s_push), 32'(tbl[i].exp_push));
         check("tbl_grant", 32'(s_grant), 32'(tbl[i].exp_grant));
         check("tbl_idx", 32'(s_idx), 32'(tbl[i].exp_idx));
      end

      // allocate 0,1,2 then all request: entry 0 first
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("seq_push_third", 32'(s_push), 32'b0100);
      cyc(0, 4'hF, 1, 0, 0);
      check("seq_first_grant", 32'(s_grant), 32'b0001);
      check("seq_first_idx", 32'(s_idx), 32'd0);
      // reuse entry 0; entry 2 is now older than new entry 0
      cyc(1, 0, 0, 0, 0);
      check("seq_reuse_push", 32'(s_push), 32'b0001);
      cyc(0, 4'b0101, 1, 0, 0);
`ifdef INT_RS_AGE_ORDER_EN
      check("seq_age_grant", 32'(s_grant), 32'b0100);
`else
      check("seq_low_grant", 32'(s_grant), 32'b0001);
`endif

      // fill up, then full behaviour and freeing entry 3
      for (int i = 0; i < D; i++)
         if (m_valid != 4'hF) cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("full_ready", 32'(s_ready), 32'd0);
      check("full_push", 32'(s_push), 32'd0);
      check("full_occ", 32'(s_occ), 32'd4);
      cyc(1, 4'b1000, 1, 0, 0);
      check("full_grant3", 32'(s_grant), 32'b1000);
      check("full_ready_grant", 32'(s_ready), 32'd0);
      cyc(1, 0, 0, 0, 0);
      check("full_push3", 32'(s_push), 32'b1000);

      // push and grant together at occupancy 2
      cyc(0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(1, 4'b0001, 1, 0, 0);
      check("both_push", 32'(s_push), 32'b0100);
      check("both_grant", 32'(s_grant), 32'b0001);
      cyc(0, 4'b0110, 0, 0, 0);
      check("both_occ", 32'(s_occ), 32'd2);
      check("fu_stall_grant", 32'(s_grant), 32'd0);
      check("fu_stall_iv", 32'(s_iv), 32'd0);

      // flush at occupancy 3
      cyc(1, 0, 0, 0, 0);
      cyc(1, 4'hF, 1, 1, 0);
      check("flush_occ_before", 32'(s_occ), 32'd3);
      check("flush_grant", 32'(s_grant), 32'd0);
      check("flush_push", 32'(s_push), 32'd0);
      check("flush_ready", 32'(s_ready), 32'd0);
      cyc(0, 0, 0, 0, 0);
      check("flush_occ_after", 32'(s_occ), 32'd0);

      // reset in the middle of dispatch
      cyc(1, 0, 0, 0, 0);
      cyc(1, 4'hF, 1, 0, 1);
      check("rst_push", 32'(s_push), 32'd0);
      check("rst_grant", 32'(s_grant), 32'd0);
      check("rst_ready", 32'(s_ready), 32'd0);
      check("rst_iv", 32'(s_iv), 32'd0);
      check("rst_idx", 32'(s_idx), 32'd0);
      cyc(0, 0, 0, 0, 0);
      check("rst_occ_after", 32'(s_occ), 32'd0);

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 3) != 0, D'($urandom), $urandom_range(0, 3) != 0,
             $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_int_rs_age_sched
`default_nettype wire
